// File: rtl/cpu_dma_arb.sv
// cpu_dma_arb: shares one synchronous memory bus between a 65C02 core and one DMA requester.
// It stalls the core through rdy and replays the read data the core missed. Define DMA_FAIR_EN to cap DMA bursts at MAX_BURST.
module cpu_dma_arb #(
    parameter int MAX_BURST  = 8,
    parameter bit SYNC_GRANT = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_ab,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_we,
    input  logic        cpu_sync,
    output logic        rdy,
    output logic [7:0]  cpu_di,
    input  logic        dma_req,
    input  logic [15:0] dma_ab,
    input  logic [7:0]  dma_do,
    input  logic        dma_we,
    output logic        dma_gnt,
    output logic [7:0]  dma_di,
    output logic        dma_rvalid,
    output logic [15:0] mem_ab,
    output logic [7:0]  mem_do,
    output logic        mem_we,
    input  logic [7:0]  mem_di
);

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_max_burst_range
        $error("cpu_dma_arb: MAX_BURST must lie in 1..255");
    end

    typedef enum logic {
        ST_CPU = 1'b0,
        ST_DMA = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic       first_q, first_d;
    logic       bypass_q, bypass_d;
    logic [7:0] hold_q, hold_d;
    logic       rvalid_q, rvalid_d;
    logic       grant_ok;
    logic       burst_done;

    // The CPU may only be stalled after a read: a stalled write would be lost.
    assign grant_ok = dma_req && !cpu_we && (!SYNC_GRANT || cpu_sync);
    assign dma_gnt  = (state_q == ST_DMA) && dma_req;

`ifdef DMA_FAIR_EN
    localparam int            CW        = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_CPU) begin
            cnt_d = '0;
        end else if (dma_gnt && (cnt_q != BURST_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign burst_done = dma_gnt && (cnt_d == BURST_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign burst_done = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        rdy     = 1'b1;
        mem_ab  = cpu_ab;
        mem_do  = cpu_do;
        mem_we  = cpu_we;
        unique case (state_q)
            ST_CPU: begin
                if (grant_ok) begin
                    state_d = ST_DMA;
                end
            end
            ST_DMA: begin
                rdy    = 1'b0;
                mem_ab = dma_ab;
                mem_do = dma_do;
                mem_we = dma_we && dma_gnt;
                if (!dma_req || burst_done) begin
                    state_d = ST_CPU;
                end
            end
        endcase
    end

    // The first DMA cycle still carries the reply to the CPU's final address.
    assign first_d  = (state_q == ST_CPU) && (state_d == ST_DMA);
    assign hold_d   = first_q ? mem_di : hold_q;
    assign bypass_d = (state_q == ST_DMA) && (state_d == ST_CPU);
    assign rvalid_d = dma_gnt && !dma_we;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_CPU;
            first_q  <= 1'b0;
            bypass_q <= 1'b0;
            hold_q   <= 8'h00;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            bypass_q <= bypass_d;
            hold_q   <= hold_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign cpu_di     = bypass_q ? hold_q : mem_di;
    assign dma_di     = mem_di;
    assign dma_rvalid = rvalid_q;

endmodule
